// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES S-box scheduler.
// Includes a byte S-box function (GF(2^8) inverse followed by the affine map).
package aes_sched_pkg;

   typedef enum logic [1:0] {IDLE, SB_RUN, KS_RUN, DONE} state_t;
   typedef enum logic {REQ_SB, REQ_KS} req_t;

   localparam int unsigned SB_BYTES = 16;
   localparam int unsigned KS_BYTES = 4;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = '0;
      aa = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_byte(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] base;
      // x^254 is the multiplicative inverse, and maps 0 to 0
      r    = 8'h01;
      base = x;
      for (int unsigned i = 0; i < 8; i++) begin
         if (i != 0) r = gf_mul(r, base);
         base = gf_mul(base, base);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single byte AES S-box, purely combinational.
module aes_sbox
   import aes_sched_pkg::*;
(
   input  logic [7:0] din,
   output logic [7:0] dout
);

   always_comb begin
      dout = sbox_byte(din);
   end

endmodule

// File: rtl/sbox_bank.sv
// Bank of NUM_SBOX parallel byte S-boxes, purely combinational.
module sbox_bank #(
   parameter int unsigned NUM_SBOX = 4
) (
   input  logic [NUM_SBOX*8-1:0] din,
   output logic [NUM_SBOX*8-1:0] dout
);

   for (genvar g = 0; g < NUM_SBOX; g++) begin : g_sbox
      aes_sbox u_sbox (
         .din  (din[g*8 +: 8]),
         .dout (dout[g*8 +: 8])
      );
   end

endmodule

// File: rtl/sbox_sched.sv
// Time-multiplexes a small S-box bank between SubBytes (128-bit) and SubWord (32-bit)
// requesters with round-robin arbitration; KS wins the first contention after reset.
module sbox_sched
   import aes_sched_pkg::*;
#(
   parameter int unsigned NUM_SBOX = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         sb_req_valid,
   output logic         sb_req_ready,
   input  logic [127:0] sb_req_data,
   output logic         sb_rsp_valid,
   output logic [127:0] sb_rsp_data,
   input  logic         ks_req_valid,
   output logic         ks_req_ready,
   input  logic [31:0]  ks_req_word,
   output logic         ks_rsp_valid,
   output logic [31:0]  ks_rsp_word,
   output logic         busy
);

   localparam int unsigned W       = NUM_SBOX * 8;
   localparam int unsigned PW      = 4;
   localparam int unsigned SB_LAST = SB_BYTES / NUM_SBOX - 1;
   localparam int unsigned KS_LAST = KS_BYTES / NUM_SBOX - 1;

   state_t         state, state_nx;
   req_t           req_id, last_grant;
   logic [PW-1:0]  ptr;
   logic [127:0]   buf_q;
   logic [127:0]   sb_res;
   logic [31:0]    ks_res;
   logic           sb_acc, ks_acc;
   logic           running, last_chunk;
   logic [W-1:0]   bank_in, bank_out;

   always_comb begin
      sb_req_ready = 1'b0;
      ks_req_ready = 1'b0;
      if (state == IDLE) begin
         if (sb_req_valid && ks_req_valid) begin
            if (last_grant == REQ_SB) ks_req_ready = 1'b1;
            else                      sb_req_ready = 1'b1;
         end else begin
            sb_req_ready = sb_req_valid;
            ks_req_ready = ks_req_valid;
         end
      end
   end

   assign sb_acc  = sb_req_valid && sb_req_ready;
   assign ks_acc  = ks_req_valid && ks_req_ready;
   assign running = (state == SB_RUN) || (state == KS_RUN);
   assign last_chunk = ((state == SB_RUN) && (ptr == PW'(SB_LAST))) ||
                       ((state == KS_RUN) && (ptr == PW'(KS_LAST)));

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (sb_acc)      state_nx = SB_RUN;
            else if (ks_acc) state_nx = KS_RUN;
         end
         SB_RUN, KS_RUN: if (last_chunk) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Bank inputs are held at zero outside RUN so idle cycles never toggle on stale data
   always_comb begin
      bank_in = '0;
      if (running) bank_in = buf_q[ptr*W +: W];
   end

   sbox_bank #(.NUM_SBOX(NUM_SBOX)) u_bank (
      .din  (bank_in),
      .dout (bank_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         req_id     <= REQ_SB;
         last_grant <= REQ_SB;
         ptr        <= '0;
         buf_q      <= '0;
         sb_res     <= '0;
         ks_res     <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               ptr <= '0;
               if (sb_acc) begin
                  buf_q      <= sb_req_data;
                  req_id     <= REQ_SB;
                  last_grant <= REQ_SB;
               end else if (ks_acc) begin
                  buf_q      <= {96'b0, ks_req_word};
                  req_id     <= REQ_KS;
                  last_grant <= REQ_KS;
               end
            end
            SB_RUN: begin
               sb_res[ptr*W +: W] <= bank_out;
               ptr <= ptr + 1'b1;
            end
            KS_RUN: begin
               ks_res[ptr*W +: W] <= bank_out;
               ptr <= ptr + 1'b1;
            end
            default: ptr <= '0;
         endcase
      end
   end

   assign sb_rsp_valid = (state == DONE) && (req_id == REQ_SB);
   assign ks_rsp_valid = (state == DONE) && (req_id == REQ_KS);
   assign sb_rsp_data  = sb_res;
   assign ks_rsp_word  = ks_res;
   assign busy         = (state != IDLE);

endmodule

// File: tb/tb_sbox_sched.sv
// Directed bench for sbox_sched: vector table plus hand sequences for contention,
// mid-operation reset, input sampling and the single-S-box configuration.
module tb_sbox_sched;

   localparam logic [127:0] SB_ZERO = 128'h0;
   localparam logic [127:0] SB_63   = {16{8'h63}};
   localparam logic [127:0] SB_53   = {16{8'h53}};
   localparam logic [127:0] SB_ED   = {16{8'hed}};
   localparam logic [127:0] SB_IDX  = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] SB_IDXS = 128'h76abd7fe2b670130c56f6bf27b777c63;

   logic         clk = 1'b0;
   logic         rst;
   logic         sb_req_valid, sb_req_ready, sb_rsp_valid;
   logic [127:0] sb_req_data, sb_rsp_data;
   logic         ks_req_valid, ks_req_ready, ks_rsp_valid;
   logic [31:0]  ks_req_word, ks_rsp_word;
   logic         busy;

   logic         u1_sb_req_valid, u1_sb_req_ready, u1_sb_rsp_valid;
   logic [127:0] u1_sb_req_data, u1_sb_rsp_data;
   logic         u1_ks_req_ready, u1_ks_rsp_valid, u1_busy;
   logic [31:0]  u1_ks_rsp_word;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sbox_sched #(.NUM_SBOX(4)) dut (
      .clk(clk), .rst(rst),
      .sb_req_valid(sb_req_valid), .sb_req_ready(sb_req_ready), .sb_req_data(sb_req_data),
      .sb_rsp_valid(sb_rsp_valid), .sb_rsp_data(sb_rsp_data),
      .ks_req_valid(ks_req_valid), .ks_req_ready(ks_req_ready), .ks_req_word(ks_req_word),
      .ks_rsp_valid(ks_rsp_valid), .ks_rsp_word(ks_rsp_word),
      .busy(busy)
   );

   sbox_sched #(.NUM_SBOX(1)) dut1 (
      .clk(clk), .rst(rst),
      .sb_req_valid(u1_sb_req_valid), .sb_req_ready(u1_sb_req_ready), .sb_req_data(u1_sb_req_data),
      .sb_rsp_valid(u1_sb_rsp_valid), .sb_rsp_data(u1_sb_rsp_data),
      .ks_req_valid(1'b0), .ks_req_ready(u1_ks_req_ready), .ks_req_word(32'h0),
      .ks_rsp_valid(u1_ks_rsp_valid), .ks_rsp_word(u1_ks_rsp_word),
      .busy(u1_busy)
   );

   typedef struct {
      logic         is_ks;
      logic [127:0] data;
      logic [127:0] exp;
      int           lat;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Caller is at a negedge; returns at the negedge of the first IDLE cycle after DONE.
   task automatic run_op(input string name, input logic is_ks, input logic [127:0] data,
                         input logic [127:0] exp, input int lat_exp);
      int n;
      int lat;
      int bad_busy;
      int other;
      logic rdy;
      logic [127:0] res;
      if (is_ks) begin ks_req_valid = 1'b1; ks_req_word = data[31:0]; end
      else       begin sb_req_valid = 1'b1; sb_req_data = data;       end
      #1;
      n = 0;
      rdy = is_ks ? ks_req_ready : sb_req_ready;
      while (!rdy && n < 50) begin
         @(negedge clk); #1;
         rdy = is_ks ? ks_req_ready : sb_req_ready;
         n++;
      end
      chk({name, " ready"}, {127'b0, rdy}, 128'd1);
      @(posedge clk);
      lat = 0; bad_busy = 0; other = 0; res = '0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 1) begin sb_req_valid = 1'b0; ks_req_valid = 1'b0; end
         if (!busy) bad_busy++;
         if (is_ks ? sb_rsp_valid : ks_rsp_valid) other++;
         if (is_ks ? ks_rsp_valid : sb_rsp_valid) begin
            lat = c;
            res = is_ks ? {96'b0, ks_rsp_word} : sb_rsp_data;
            break;
         end
      end
      chk({name, " latency"}, 128'(lat), 128'(lat_exp));
      chk({name, " data"}, res, exp);
      chk({name, " busy during op"}, 128'(bad_busy), 128'd0);
      chk({name, " other rsp"}, 128'(other), 128'd0);
      @(negedge clk);
      chk({name, " rsp pulse width"}, {126'b0, sb_rsp_valid, ks_rsp_valid}, 128'd0);
      chk({name, " idle busy"}, {127'b0, busy}, 128'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      int lat;
      logic [127:0] res;

      vecs[0] = '{is_ks: 1'b0, data: SB_ZERO,            exp: SB_63,               lat: 5};
      vecs[1] = '{is_ks: 1'b1, data: 128'h00010203,      exp: 128'h637c777b,       lat: 2};
      vecs[2] = '{is_ks: 1'b0, data: SB_IDX,             exp: SB_IDXS,             lat: 5};
      vecs[3] = '{is_ks: 1'b1, data: 128'h53535353,      exp: 128'hedededed,       lat: 2};
      vecs[4] = '{is_ks: 1'b1, data: 128'h0f0e0d0c,      exp: 128'h76abd7fe,       lat: 2};

      rst = 1'b1;
      sb_req_valid = 1'b0; sb_req_data = '0;
      ks_req_valid = 1'b0; ks_req_word = '0;
      u1_sb_req_valid = 1'b0; u1_sb_req_data = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset busy", {127'b0, busy}, 128'd0);
      chk("reset rsp valids", {126'b0, sb_rsp_valid, ks_rsp_valid}, 128'd0);
      chk("reset sb data", sb_rsp_data, 128'd0);
      chk("reset ks word", {96'b0, ks_rsp_word}, 128'd0);
      chk("reset readies", {126'b0, sb_req_ready, ks_req_ready}, 128'd0);
      rst = 1'b0;

      // First contention after reset: KS must win
      @(negedge clk);
      sb_req_valid = 1'b1; sb_req_data = SB_53;
      ks_req_valid = 1'b1; ks_req_word = 32'h0;
      #1;
      chk("contend1 ready {sb,ks}", {126'b0, sb_req_ready, ks_req_ready}, 128'b01);
      @(negedge clk);
      chk("contend1 c1 sb_ready", {127'b0, sb_req_ready}, 128'd0);
      chk("contend1 c1 busy", {127'b0, busy}, 128'd1);
      @(negedge clk);
      chk("contend1 ks rsp valid", {127'b0, ks_rsp_valid}, 128'd1);
      chk("contend1 ks rsp word", {96'b0, ks_rsp_word}, 128'h63636363);
      chk("contend1 c2 sb_ready", {127'b0, sb_req_ready}, 128'd0);
      ks_req_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("contend1 sb ready in idle", {127'b0, sb_req_ready}, 128'd1);
      @(negedge clk);
      sb_req_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("contend1 sb rsp valid", {127'b0, sb_rsp_valid}, 128'd1);
      chk("contend1 sb rsp data", sb_rsp_data, SB_ED);
      @(negedge clk);
      chk("contend1 sb pulse width", {127'b0, sb_rsp_valid}, 128'd0);

      for (int i = 0; i < 5; i++) begin
         run_op($sformatf("vec%0d", i), vecs[i].is_ks, vecs[i].data, vecs[i].exp, vecs[i].lat);
      end

      // Valid held with data changing after the accepting edge
      sb_req_valid = 1'b1; sb_req_data = SB_ZERO;
      #1;
      chk("hold ready", {127'b0, sb_req_ready}, 128'd1);
      @(posedge clk); #1;
      sb_req_data = SB_53;
      repeat (5) @(negedge clk);
      chk("hold rsp valid", {127'b0, sb_rsp_valid}, 128'd1);
      chk("hold rsp data", sb_rsp_data, SB_63);
      sb_req_valid = 1'b0;
      @(negedge clk);

      // Reset during SB_RUN cycle 2
      sb_req_valid = 1'b1; sb_req_data = SB_53;
      @(posedge clk);
      @(negedge clk);
      sb_req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst busy", {127'b0, busy}, 128'd0);
      chk("midrst sb data", sb_rsp_data, 128'd0);
      chk("midrst ks word", {96'b0, ks_rsp_word}, 128'd0);
      pulses = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (sb_rsp_valid || ks_rsp_valid || busy) pulses++;
      end
      chk("midrst no pulse", 128'(pulses), 128'd0);
      run_op("post-reset ks", 1'b1, 128'h00010203, 128'h637c777b, 2);

      // Contention after a KS grant: SB must win, then KS follows
      sb_req_valid = 1'b1; sb_req_data = SB_IDX;
      ks_req_valid = 1'b1; ks_req_word = 32'h53535353;
      #1;
      chk("contend2 ready {sb,ks}", {126'b0, sb_req_ready, ks_req_ready}, 128'b10);
      @(negedge clk);
      sb_req_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("contend2 sb rsp valid", {127'b0, sb_rsp_valid}, 128'd1);
      chk("contend2 sb rsp data", sb_rsp_data, SB_IDXS);
      @(negedge clk);
      #1;
      chk("contend2 ks ready", {127'b0, ks_req_ready}, 128'd1);
      @(negedge clk);
      ks_req_valid = 1'b0;
      @(negedge clk);
      chk("contend2 ks rsp valid", {127'b0, ks_rsp_valid}, 128'd1);
      chk("contend2 ks rsp word", {96'b0, ks_rsp_word}, 128'hedededed);

      // Single S-box instance
      @(negedge clk);
      u1_sb_req_valid = 1'b1; u1_sb_req_data = SB_IDX;
      #1;
      chk("n1 ready", {127'b0, u1_sb_req_ready}, 128'd1);
      @(posedge clk);
      lat = 0; res = '0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (c == 1) u1_sb_req_valid = 1'b0;
         if (u1_sb_rsp_valid) begin lat = c; res = u1_sb_rsp_data; break; end
      end
      chk("n1 latency", 128'(lat), 128'd17);
      chk("n1 data", res, SB_IDXS);
      chk("n1 ks idle", {127'b0, u1_ks_rsp_valid}, 128'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
